rib_xbar_arb: RTL and testbench

- Parametrised next-generation RIB interconnect: NUM_M masters to NUM_S slaves over a shared single-transaction bus.
- Selectable fixed-priority or round-robin arbitration.
- Multi-cycle slave handshake with grant lock and a watchdog timeout.
- Unmapped-address error response.
- Sits in the SoC top between the cores/PC-fetch/JTAG/UART-debug masters and the ROM/RAM/peripheral slaves; replaces the fixed 4x8 bus.

---
 rtl/rib_pkg.sv | 18 +
 rtl/rib_rr_arbiter.sv | 44 ++++
 rtl/rib_xbar_arb.sv | 184 ++++++++++++++++++
 tb/tb_rib_xbar_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_pkg.sv
// Shared constants and helpers for the RIB crossbar arbiter.
// Holds arbitration modes, FSM encoding, default error data and the slave decode.
package rib_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [31:0] RIB_ERR_DATA = 32'hDEAD_BEEF;

  // A select field maps to a slave only when it indexes an existing port.
  function automatic logic rib_sel_mapped(input int unsigned sel, input int unsigned num_s);
    return (sel < num_s);
  endfunction

endpackage

// File: rtl/rib_rr_arbiter.sv
// Combinational master arbiter: fixed priority or round-robin from a pointer,
// with a lock input that pins the grant to an already-accepted master.
module rib_rr_arbiter
  import rib_pkg::*;
#(
  parameter int unsigned NUM_M    = 4,
  parameter int unsigned ARB_MODE = ARB_FIXED,
  localparam int unsigned MIW     = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [MIW-1:0]   i_ptr,
  input  logic             i_lock,
  input  logic [MIW-1:0]   i_lock_idx,
  output logic [NUM_M-1:0] o_gnt,
  output logic [MIW-1:0]   o_idx
);

  int unsigned w_start;
  logic        w_found;

  always_comb begin
    w_start = (ARB_MODE == ARB_RR) ? 32'(i_ptr) : 0;
    w_found = 1'b0;
    o_idx   = '0;
    o_gnt   = '0;
    if (i_lock) begin
      o_idx = i_lock_idx;
    end else begin
      // Walk the priority order starting at the pointer, wrapping past NUM_M-1.
      for (int unsigned k = 0; k < NUM_M; k++) begin
        for (int unsigned m = 0; m < NUM_M; m++) begin
          if (!w_found && i_req[m] && (m == ((w_start + k) % NUM_M))) begin
            w_found = 1'b1;
            o_idx   = MIW'(m);
          end
        end
      end
    end
    for (int unsigned m = 0; m < NUM_M; m++) begin
      o_gnt[m] = (i_lock || w_found) && (o_idx == MIW'(m));
    end
  end

endmodule

// File: rtl/rib_xbar_arb.sv
// RIB interconnect: NUM_M masters share one transaction path to NUM_S slaves,
// with multi-cycle slave wait, watchdog timeout and unmapped-address errors.
module rib_xbar_arb
  import rib_pkg::*;
#(
  parameter int unsigned   NUM_M    = 4,
  parameter int unsigned   NUM_S    = 8,
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   SEL_W    = 4,
  parameter int unsigned   ARB_MODE = ARB_FIXED,
  parameter int unsigned   TIMEOUT  = 256,
  parameter logic [DW-1:0] ERR_DATA = DW'(RIB_ERR_DATA)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_data_i,
  output logic [NUM_M*DW-1:0] m_data_o,
  output logic [NUM_M-1:0]    m_ready_o,
  output logic [NUM_S-1:0]    s_req_o,
  output logic [NUM_S-1:0]    s_we_o,
  output logic [NUM_S*AW-1:0] s_addr_o,
  output logic [NUM_S*DW-1:0] s_data_o,
  input  logic [NUM_S*DW-1:0] s_data_i,
  input  logic [NUM_S-1:0]    s_ready_i,
  output logic                hold_flag_o,
  output logic                err_o,
  output logic [AW-1:0]       err_addr_o
);

  localparam int unsigned MIW    = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned CW     = $clog2(TIMEOUT);
  localparam logic [AW-1:0] AMASK = {{SEL_W{1'b0}}, {(AW-SEL_W){1'b1}}};

  logic [0:0]       r_state;
  logic [MIW-1:0]   r_gnt;
  logic [SEL_W-1:0] r_idx;
  logic [MIW-1:0]   r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [AW-1:0]    r_err_addr;

  logic [NUM_M-1:0] w_req;
  logic [NUM_M-1:0] w_gnt;
  logic [MIW-1:0]   w_gidx;
  logic             w_wait;
  logic             w_live;
  logic             w_we;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_wdata;
  logic [SEL_W-1:0] w_sel;
  logic             w_mapped;
  logic             w_sready;
  logic [DW-1:0]    w_srdata;
  logic             w_done_ok;
  logic             w_timeout;
  logic             w_unmapped;
  logic             w_complete;
  logic             w_err;
  logic             w_route;
  logic [DW-1:0]    w_rdata;

  assign w_req  = rst ? '0 : m_req_i;
  assign w_wait = (r_state == WAIT);

  rib_rr_arbiter #(
    .NUM_M   (NUM_M),
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .i_lock    (w_wait),
    .i_lock_idx(r_gnt),
    .o_gnt     (w_gnt),
    .o_idx     (w_gidx)
  );

  always_comb begin
    w_live  = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int unsigned m = 0; m < NUM_M; m++) begin
      if (w_gidx == MIW'(m)) begin
        w_live  = w_req[m];
        w_we    = m_we_i[m];
        w_addr  = m_addr_i[m*AW +: AW];
        w_wdata = m_data_i[m*DW +: DW];
      end
    end
  end

  // In WAIT the slave index stays latched even if the master's address moves.
  assign w_sel    = w_wait ? r_idx : w_addr[AW-1 -: SEL_W];
  assign w_mapped = rib_sel_mapped(32'(w_sel), NUM_S);

  always_comb begin
    w_sready = 1'b0;
    w_srdata = '0;
    for (int unsigned s = 0; s < NUM_S; s++) begin
      if (w_sel == SEL_W'(s)) begin
        w_sready = s_ready_i[s];
        w_srdata = s_data_i[s*DW +: DW];
      end
    end
  end

  assign w_done_ok  = w_live && w_mapped && w_sready;
  assign w_timeout  = w_wait && w_live && !w_sready && (r_cnt == CW'(TIMEOUT-1));
  assign w_unmapped = !w_wait && w_live && !w_mapped;
  assign w_complete = w_done_ok || w_timeout || w_unmapped;
  assign w_err      = w_timeout || w_unmapped;
  assign w_route    = w_live && w_mapped && !w_timeout;
  assign w_rdata    = w_err ? ERR_DATA : w_srdata;

  always_comb begin
    s_req_o   = '0;
    s_we_o    = '0;
    s_addr_o  = '0;
    s_data_o  = '0;
    m_ready_o = '0;
    m_data_o  = '0;
    for (int unsigned s = 0; s < NUM_S; s++) begin
      if (w_route && (w_sel == SEL_W'(s))) begin
        s_req_o[s]            = 1'b1;
        s_we_o[s]             = w_we;
        s_addr_o[s*AW +: AW]  = w_addr & AMASK;
        s_data_o[s*DW +: DW]  = w_wdata;
      end
    end
    for (int unsigned m = 0; m < NUM_M; m++) begin
      if (w_complete && (w_gidx == MIW'(m))) begin
        m_ready_o[m]         = 1'b1;
        m_data_o[m*DW +: DW] = w_rdata;
      end
    end
  end

  assign hold_flag_o = |(w_req & ~w_gnt);
  assign err_o       = r_err & ~rst;
  assign err_addr_o  = rst ? '0 : r_err_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_err <= w_err;
      if (w_err) begin
        r_err_addr <= w_addr;
      end
      if (w_complete) begin
        r_ptr <= (w_gidx == MIW'(NUM_M-1)) ? '0 : w_gidx + MIW'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_live && w_mapped && !w_sready) begin
            r_state <= WAIT;
            r_gnt   <= w_gidx;
            r_idx   <= w_sel;
            r_cnt   <= '0;
          end
        end
        WAIT: begin
          if (!w_live || w_complete) begin
            r_state <= IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_xbar_arb.sv
// Randomized and directed check of rib_xbar_arb (fixed and round-robin instances)
// against a transaction-level reference model of the bus rules.
module tb_rib_xbar_arb;

  localparam int NM = 4;
  localparam int NS = 8;
  localparam int TO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NM-1:0]     m_req, m_we;
  logic [NM*32-1:0]  m_addr, m_wdata;
  logic [NS*32-1:0]  s_rdata;
  logic [NS-1:0]     s_ready;

  logic [NM*32-1:0]  o_mdata [2];
  logic [NM-1:0]     o_mrdy  [2];
  logic [NS-1:0]     o_sreq  [2];
  logic [NS-1:0]     o_swe   [2];
  logic [NS*32-1:0]  o_saddr [2];
  logic [NS*32-1:0]  o_sdata [2];
  logic              o_hold  [2];
  logic              o_err   [2];
  logic [31:0]       o_erra  [2];

  int total = 0;
  int bad   = 0;

  // Reference model state, one set per instance (0 = fixed, 1 = round-robin).
  int          busy [2];
  int          lg   [2];
  int          ls   [2];
  int          cnt  [2];
  int          ptr  [2];
  logic        errq [2];
  logic [31:0] erra [2];

  rib_xbar_arb #(
    .NUM_M(NM), .NUM_S(NS), .AW(32), .DW(32), .SEL_W(4),
    .ARB_MODE(0), .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) u_fix (
    .clk(clk), .rst(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_data_i(m_wdata),
    .m_data_o(o_mdata[0]), .m_ready_o(o_mrdy[0]),
    .s_req_o(o_sreq[0]), .s_we_o(o_swe[0]), .s_addr_o(o_saddr[0]), .s_data_o(o_sdata[0]),
    .s_data_i(s_rdata), .s_ready_i(s_ready),
    .hold_flag_o(o_hold[0]), .err_o(o_err[0]), .err_addr_o(o_erra[0])
  );

  rib_xbar_arb #(
    .NUM_M(NM), .NUM_S(NS), .AW(32), .DW(32), .SEL_W(4),
    .ARB_MODE(1), .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) u_rr (
    .clk(clk), .rst(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_data_i(m_wdata),
    .m_data_o(o_mdata[1]), .m_ready_o(o_mrdy[1]),
    .s_req_o(o_sreq[1]), .s_we_o(o_swe[1]), .s_addr_o(o_saddr[1]), .s_data_o(o_sdata[1]),
    .s_data_i(s_rdata), .s_ready_i(s_ready),
    .hold_flag_o(o_hold[1]), .err_o(o_err[1]), .err_addr_o(o_erra[1])
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_check(input int md);
    logic [NM-1:0]    e_mrdy;
    logic [NM*32-1:0] e_mdata;
    logic [NS-1:0]    e_sreq, e_swe;
    logic [NS*32-1:0] e_saddr, e_sdata;
    logic             e_hold, e_err, live, done, errnow;
    logic [31:0]      e_erra, a, rd;
    int               g, s, m;
    string            p;
    p = (md == 0) ? "fx" : "rr";
    e_mrdy = '0; e_mdata = '0; e_sreq = '0; e_swe = '0; e_saddr = '0; e_sdata = '0;
    e_hold = 1'b0; e_err = 1'b0; e_erra = '0;
    if (rst) begin
      busy[md] = 0; ptr[md] = 0; cnt[md] = 0; errq[md] = 1'b0; erra[md] = '0;
    end else begin
      e_err = errq[md]; e_erra = erra[md];
      g = -1;
      if (busy[md] != 0) g = lg[md];
      else
        for (int k = 0; k < NM; k++) begin
          m = (md == 1) ? (ptr[md] + k) % NM : k;
          if (g < 0 && m_req[m]) g = m;
        end
      for (int i = 0; i < NM; i++)
        if (m_req[i] && i != g) e_hold = 1'b1;
      live = (g >= 0) && m_req[g];
      errnow = 1'b0; done = 1'b0; a = '0; rd = '0;
      if (live) begin
        a = m_addr[g*32 +: 32];
        s = (busy[md] != 0) ? ls[md] : int'(a[31:28]);
        if (s >= NS) begin
          done = 1'b1; errnow = 1'b1;
        end else if (s_ready[s]) begin
          done = 1'b1; rd = s_rdata[s*32 +: 32];
        end else if (busy[md] != 0 && cnt[md] == TO - 1) begin
          done = 1'b1; errnow = 1'b1;
        end else if (busy[md] == 0) begin
          busy[md] = 1; lg[md] = g; ls[md] = s; cnt[md] = 0;
        end else begin
          cnt[md]++;
        end
        if (s < NS && !(errnow && busy[md] != 0)) begin
          e_sreq[s] = 1'b1;
          e_swe[s] = m_we[g];
          e_saddr[s*32 +: 32] = {4'h0, a[27:0]};
          e_sdata[s*32 +: 32] = m_wdata[g*32 +: 32];
        end
        if (done) begin
          e_mrdy[g] = 1'b1;
          e_mdata[g*32 +: 32] = errnow ? ERRD : rd;
          busy[md] = 0;
          ptr[md] = (g + 1) % NM;
        end
      end else begin
        busy[md] = 0;
      end
      errq[md] = errnow;
      if (errnow) erra[md] = a;
    end
    chk({p, ".mrdy"},  o_mrdy[md],  e_mrdy);
    chk({p, ".mdata"}, o_mdata[md], e_mdata);
    chk({p, ".sreq"},  o_sreq[md],  e_sreq);
    chk({p, ".swe"},   o_swe[md],   e_swe);
    chk({p, ".saddr"}, o_saddr[md], e_saddr);
    chk({p, ".sdata"}, o_sdata[md], e_sdata);
    chk({p, ".hold"},  o_hold[md],  e_hold);
    chk({p, ".err"},   o_err[md],   e_err);
    chk({p, ".erra"},  o_erra[md],  e_erra);
  endtask

  task automatic cyc_check();
    for (int s = 0; s < NS; s++) s_rdata[s*32 +: 32] = $urandom;
    #4;
    model_check(0);
    model_check(1);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    cyc_check();
    cyc_end();
  endtask

  task automatic put(input int m, input logic r, input logic [31:0] a, input logic w);
    m_req[m] = r;
    m_addr[m*32 +: 32] = a;
    m_we[m] = w;
    m_wdata[m*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    m_req = '0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; s_rdata = '0; s_ready = '1;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; lg[i] = 0; ls[i] = 0; cnt[i] = 0; ptr[i] = 0; errq[i] = 1'b0; erra[i] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // m0 and m2 contend for slave 1; m0 wins under both modes from reset.
    s_ready = '1;
    put(0, 1'b1, 32'h1000_0004, 1'b0);
    put(2, 1'b1, 32'h1000_0004, 1'b1);
    cyc_check();
    chk("tp1.mrdy", o_mrdy[0], 4'b0001);
    chk("tp1.saddr", o_saddr[0][63:32], 32'h0000_0004);
    chk("tp1.hold", o_hold[0], 1'b1);
    cyc_end();
    m_req[0] = 1'b0;
    cyc_check();
    chk("tp1.m2", o_mrdy[0], 4'b0100);
    cyc_end();

    // All masters stream to slave 2; round-robin rotates through them.
    do_reset();
    for (int m = 0; m < NM; m++) put(m, 1'b1, 32'h2000_0010 + m, 1'b0);
    for (int c = 0; c < 5; c++) begin
      cyc_check();
      chk("tp2.rr", o_mrdy[1], 4'b0001 << (c % NM));
      cyc_end();
    end

    // m1 waits on slave 7 for five cycles while m3 is held off.
    do_reset();
    put(1, 1'b1, 32'h7000_0020, 1'b0);
    put(3, 1'b1, 32'h2000_0030, 1'b0);
    s_ready = 8'h7F;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) s_ready = '1;
      cyc_check();
      if (c < 6) chk("tp3.hold", o_hold[0], 1'b1);
      else chk("tp3.rdy", o_mrdy[0], 4'b0010);
      cyc_end();
    end
    m_req = '0;
    cyc();

    // Slave 3 never ready: watchdog forces an error completion.
    do_reset();
    put(1, 1'b1, 32'h3000_0040, 1'b0);
    s_ready = 8'hF7;
    for (int c = 1; c <= 9; c++) begin
      cyc_check();
      if (c == 9) begin
        chk("tp4.rdy", o_mrdy[0], 4'b0010);
        chk("tp4.data", o_mdata[0][63:32], ERRD);
      end
      cyc_end();
    end
    m_req = '0;
    cyc_check();
    chk("tp4.err", o_err[0], 1'b1);
    chk("tp4.erra", o_erra[0], 32'h3000_0040);
    cyc_end();
    cyc();

    // Unmapped slave index 10.
    s_ready = '1;
    put(0, 1'b1, 32'hA000_0000, 1'b0);
    cyc_check();
    chk("tp5.sreq", o_sreq[0], 8'h00);
    chk("tp5.data", o_mdata[0][31:0], ERRD);
    cyc_end();
    m_req = '0;
    cyc_check();
    chk("tp5.err", o_err[0], 1'b1);
    cyc_end();

    // Reset while waiting abandons the transaction.
    put(1, 1'b1, 32'h5000_0000, 1'b0);
    s_ready = 8'hDF;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc_check();
    chk("tp6.rdy", o_mrdy[1], 4'b0000);
    cyc_end();
    rst = 1'b0;
    s_ready = '1;
    put(1, 1'b1, 32'h0000_0008, 1'b0);
    put(2, 1'b1, 32'h0000_000C, 1'b0);
    cyc();
    m_req = '0;
    cyc();

    // Random traffic with persistent requests, slow upper slaves and sporadic reset.
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < NM; m++) begin
        if ($urandom_range(0, 99) < 15) begin
          int sel;
          sel = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
          put(m, ($urandom_range(0, 99) < 60), {sel[3:0], 28'($urandom)}, 1'($urandom));
        end
      end
      for (int s = 0; s < NS; s++)
        s_ready[s] = ($urandom_range(0, 99) < ((s < 4) ? 80 : 25));
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
